detect_alarm: RTL and testbench

//   Parametrised alarm/indicator stage behind the word detector (detect_NN result_dv/result).

---
 rtl/detect_alarm.sv | 139 +++++++++++++
 tb/tb_detect_alarm.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/detect_alarm.sv
// Alarm stage behind the word detector: fires a square-wave tone after HIT_COUNT consecutive
// target-class results, then holds off before re-arming. Optional: DETECT_ALARM_RETRIGGER_EN.
module detect_alarm #(
    parameter int unsigned CLASS_W        = 2,
    parameter int unsigned TARGET_CLASS   = 1,
    parameter int unsigned HIT_COUNT      = 2,
    parameter int unsigned BEEP_CYCLES    = 50000000,
    parameter int unsigned TONE_DIV       = 12500,
    parameter int unsigned HOLDOFF_CYCLES = 0,
    parameter int unsigned CNT_W          = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               result_dv,
    input  logic [CLASS_W-1:0] result,
    input  logic               enable,
    output logic               beep,
    output logic [CLASS_W-1:0] led,
    output logic               busy,
    output logic [7:0]         alarm_cnt
);

    localparam int unsigned STREAK_W = (HIT_COUNT > 1) ? $clog2(HIT_COUNT + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_LAST = STREAK_W'(HIT_COUNT - 1);
    localparam logic [CNT_W-1:0]    BEEP_LAST   = CNT_W'(BEEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]    TONE_LAST   = CNT_W'(TONE_DIV - 1);
    localparam logic [CNT_W-1:0]    HOLD_LAST   =
        CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
    localparam logic [CLASS_W-1:0]  TARGET      = CLASS_W'(TARGET_CLASS);

`ifdef DETECT_ALARM_RETRIGGER_EN
    localparam bit RETRIGGER = 1'b1;
`else
    localparam bit RETRIGGER = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StBeep, StHoldoff} state_e;

    state_e              state;
    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_next;
    logic [CNT_W-1:0]    dur_cnt;
    logic [CNT_W-1:0]    tone_cnt;
    logic                hit;
    logic                fire;
    logic                restart;
    logic [7:0]          alarm_inc;

    assign hit       = result_dv && enable && (result == TARGET);
    assign fire      = hit && (streak == STREAK_LAST);
    assign restart   = RETRIGGER && fire;
    assign alarm_inc = (alarm_cnt == 8'hFF) ? alarm_cnt : alarm_cnt + 8'd1;

    // Streak clears on a firing hit, a non-target result, or whenever arming is disabled.
    always_comb begin
        streak_next = streak;
        if (fire || !enable || (result_dv && !hit)) begin
            streak_next = '0;
        end else if (hit) begin
            streak_next = streak + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            streak    <= '0;
            dur_cnt   <= '0;
            tone_cnt  <= '0;
            beep      <= 1'b0;
            led       <= '0;
            busy      <= 1'b0;
            alarm_cnt <= '0;
        end else begin
            if (result_dv) begin
                led <= result;
            end

            unique case (state)
                StIdle: begin
                    streak <= streak_next;
                    if (fire) begin
                        state     <= StBeep;
                        busy      <= 1'b1;
                        beep      <= 1'b1;
                        dur_cnt   <= '0;
                        tone_cnt  <= '0;
                        alarm_cnt <= alarm_inc;
                    end
                end

                StBeep: begin
                    streak <= RETRIGGER ? streak_next : '0;
                    if (tone_cnt == TONE_LAST) begin
                        tone_cnt <= '0;
                        beep     <= ~beep;
                    end else begin
                        tone_cnt <= tone_cnt + 1'b1;
                    end
                    // Retrigger restarts the duration only; tone phase runs on unbroken.
                    if (restart) begin
                        dur_cnt   <= '0;
                        alarm_cnt <= alarm_inc;
                    end else if (dur_cnt == BEEP_LAST) begin
                        beep    <= 1'b0;
                        dur_cnt <= '0;
                        if (HOLDOFF_CYCLES == 0) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end else begin
                            state <= StHoldoff;
                        end
                    end else begin
                        dur_cnt <= dur_cnt + 1'b1;
                    end
                end

                StHoldoff: begin
                    streak <= '0;
                    beep   <= 1'b0;
                    if (dur_cnt == HOLD_LAST) begin
                        state   <= StIdle;
                        busy    <= 1'b0;
                        dur_cnt <= '0;
                    end else begin
                        dur_cnt <= dur_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    beep  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_detect_alarm.sv
// Scoreboard bench for detect_alarm: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_detect_alarm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       result_dv = 1'b0;
    logic [1:0] result = 2'd0;
    logic       enable = 1'b1;
    logic       beep;
    logic [1:0] led;
    logic       busy;
    logic [7:0] alarm_cnt;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int acnt = 0;

    typedef struct {
        int         cyc;
        logic       beep;
        logic       busy;
        logic [1:0] led;
        logic [7:0] cnt;
        string      nm;
    } exp_t;

    exp_t sb[$];

    detect_alarm #(
        .CLASS_W        (2),
        .TARGET_CLASS   (1),
        .HIT_COUNT      (2),
        .BEEP_CYCLES    (20),
        .TONE_DIV       (3),
        .HOLDOFF_CYCLES (10),
        .CNT_W          (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .result_dv (result_dv),
        .result    (result),
        .enable    (enable),
        .beep      (beep),
        .led       (led),
        .busy      (busy),
        .alarm_cnt (alarm_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL %s: not sampled (due cycle %0d, now %0d)", sb[i].nm, sb[i].cyc, cyc);
                sb.delete(i);
            end else if (sb[i].cyc == cyc) begin
                vectors++;
                if ({beep, busy, led, alarm_cnt} !== {sb[i].beep, sb[i].busy, sb[i].led, sb[i].cnt})
                begin
                    miscompares++;
                    $display("FAIL %s: got beep=%b busy=%b led=%0d cnt=%0d, want beep=%b busy=%b led=%0d cnt=%0d",
                             sb[i].nm, beep, busy, led, alarm_cnt,
                             sb[i].beep, sb[i].busy, sb[i].led, sb[i].cnt);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [1:0] r);
        result_dv = 1'b1;
        result    = r;
        step();
        result_dv = 1'b0;
    endtask

    task automatic expect_at(input int off, input logic b, input logic bz, input logic [1:0] l,
                             input int c, input string nm);
        exp_t e;
        e.cyc  = cyc + off;
        e.beep = b;
        e.busy = bz;
        e.led  = l;
        e.cnt  = 8'(c);
        e.nm   = nm;
        sb.push_back(e);
    endtask

    // Tone of period 6 (3 high, 3 low) starting high at the firing cycle.
    task automatic expect_seq(input int len, input int beep_len, input int busy_len,
                              input int cnt_at, input int c0, input int c1,
                              input logic [1:0] l, input string nm);
        for (int k = 0; k < len; k++) begin
            expect_at(k, (k < beep_len) && (((k / 3) % 2) == 0), k < busy_len, l,
                      (k >= cnt_at) ? c1 : c0, $sformatf("%s_k%0d", nm, k));
        end
    endtask

    initial begin
        repeat (2) step();
        reset = 1'b1;
        step();
        expect_at(0, 1'b0, 1'b0, 2'd0, 0, "reset_idle");

        // Basic fire
        pulse(2'd1);
        expect_at(0, 1'b0, 1'b0, 2'd1, 0, "one_hit");
        pulse(2'd1);
        acnt = 1;
        expect_seq(32, 20, 30, 0, acnt, acnt, 2'd1, "single_fire");
        repeat (32) step();

        // Broken streak
        pulse(2'd1);
        pulse(2'd2);
        expect_at(0, 1'b0, 1'b0, 2'd2, acnt, "led_two");
        pulse(2'd1);
        expect_at(0, 1'b0, 1'b0, 2'd1, acnt, "streak_broken");
        step();
        expect_at(0, 1'b0, 1'b0, 2'd1, acnt, "still_idle");
        pulse(2'd1);
        acnt = 2;
        expect_seq(32, 20, 30, 0, acnt, acnt, 2'd1, "rearm_fire");
        repeat (32) step();

        // Enable gating, and enable drop mid-beep
        enable = 1'b0;
        pulse(2'd1);
        pulse(2'd1);
        expect_at(0, 1'b0, 1'b0, 2'd1, acnt, "disabled_hits");
        step();
        expect_at(0, 1'b0, 1'b0, 2'd1, acnt, "disabled_idle");
        enable = 1'b1;
        pulse(2'd1);
        pulse(2'd1);
        acnt = 3;
        expect_seq(32, 20, 30, 0, acnt, acnt, 2'd1, "enable_drop");
        repeat (4) step();
        enable = 1'b0;
        repeat (28) step();
        enable = 1'b1;

        // Hits during beep
        pulse(2'd1);
        pulse(2'd1);
        acnt = 4;
`ifdef DETECT_ALARM_RETRIGGER_EN
        expect_seq(37, 25, 35, 5, 4, 5, 2'd1, "hits_in_beep");
        acnt = 5;
`else
        expect_seq(37, 20, 30, 5, 4, 4, 2'd1, "hits_in_beep");
`endif
        repeat (3) step();
        pulse(2'd1);
        pulse(2'd1);
        repeat (32) step();

        // Hits during holdoff are ignored
        pulse(2'd1);
        pulse(2'd1);
        acnt++;
        expect_seq(32, 20, 30, 0, acnt, acnt, 2'd1, "holdoff_ignore");
        repeat (22) step();
        pulse(2'd1);
        pulse(2'd1);
        repeat (8) step();
        pulse(2'd1);
        expect_at(0, 1'b0, 1'b0, 2'd1, acnt, "one_after_holdoff");
        pulse(2'd1);
        acnt++;
        expect_seq(3, 20, 30, 0, acnt, acnt, 2'd1, "led_beep_pre");
        repeat (2) step();
        pulse(2'd2);
        expect_at(0, 1'b0, 1'b1, 2'd2, acnt, "led_in_beep");
        repeat (29) step();

        // Saturation
        while (acnt < 254) begin
            pulse(2'd1);
            pulse(2'd1);
            acnt++;
            repeat (30) step();
        end
        expect_at(0, 1'b0, 1'b0, 2'd1, 254, "pre_sat");
        step();
        pulse(2'd1);
        pulse(2'd1);
        expect_seq(32, 20, 30, 0, 255, 255, 2'd1, "sat_255");
        repeat (32) step();
        pulse(2'd1);
        pulse(2'd1);
        expect_seq(5, 20, 30, 0, 255, 255, 2'd1, "sat_hold");

        // Asynchronous reset mid-beep
        repeat (5) step();
        #1;
        reset = 1'b0;
        expect_at(0, 1'b0, 1'b0, 2'd0, 0, "async_reset");
        step();
        expect_at(0, 1'b0, 1'b0, 2'd0, 0, "reset_held");
        reset = 1'b1;
        step();
        expect_at(0, 1'b0, 1'b0, 2'd0, 0, "post_reset_idle");
        pulse(2'd1);
        pulse(2'd1);
        expect_seq(32, 20, 30, 0, 1, 1, 2'd1, "post_reset_fire");
        repeat (32) step();

        repeat (2) step();
        foreach (sb[i]) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: left unchecked (due cycle %0d)", sb[i].nm, sb[i].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
